// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter sharing one register datapath between N_REQ requesters; each access is a write-then-readback.
// Define REG_ACCESS_ARBITER_READBACK_CHECK_EN to raise err when the readback differs from the written data.
module reg_access_arbiter #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   err,
  output logic                   busy,
  output logic                   reg_enable,
  output logic [WIDTH-1:0]       reg_data,
  output logic                   reg_reset_n,
  input  logic [WIDTH-1:0]       reg_outa
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t           state, state_d;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_d;
  logic [IDX_W-1:0] win_idx, win_idx_d;
  logic [IDX_W-1:0] pick;
  logic             found;
  logic [N_REQ-1:0] gnt_d, done_d;
  logic [WIDTH-1:0] rd_data_d, reg_data_d;
  logic             reg_enable_d, busy_d;
  int               cand;

  function automatic logic [N_REQ-1:0] to_one_hot(input logic [IDX_W-1:0] idx);
    to_one_hot = '0;
    to_one_hot[idx] = 1'b1;
  endfunction

  // Round-robin search: first requester after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    cand  = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = IDX_W'(cand);
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state;
    rr_ptr_d     = rr_ptr;
    win_idx_d    = win_idx;
    gnt_d        = '0;
    done_d       = '0;
    reg_enable_d = 1'b0;
    reg_data_d   = reg_data;
    rd_data_d    = rd_data;
    case (state)
      S_IDLE: begin
        if (found) begin
          state_d      = S_WRITE;
          win_idx_d    = pick;
          rr_ptr_d     = pick;
          gnt_d        = to_one_hot(pick);
          reg_enable_d = 1'b1;
          reg_data_d   = req_data[int'(pick)*WIDTH +: WIDTH];
        end
      end
      S_WRITE:   state_d = S_CAPTURE;
      S_CAPTURE: begin
        state_d   = S_DONE;
        rd_data_d = reg_outa;
        done_d    = to_one_hot(win_idx);
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      rr_ptr      <= IDX_W'(N_REQ - 1);
      win_idx     <= '0;
      gnt         <= '0;
      done        <= '0;
      rd_data     <= '0;
      busy        <= 1'b0;
      reg_enable  <= 1'b0;
      reg_data    <= '0;
      reg_reset_n <= 1'b0;
    end else begin
      state       <= state_d;
      rr_ptr      <= rr_ptr_d;
      win_idx     <= win_idx_d;
      gnt         <= gnt_d;
      done        <= done_d;
      rd_data     <= rd_data_d;
      busy        <= busy_d;
      reg_enable  <= reg_enable_d;
      reg_data    <= reg_data_d;
      reg_reset_n <= 1'b1;
    end
  end

`ifdef REG_ACCESS_ARBITER_READBACK_CHECK_EN
  // reg_data still holds the written value during CAPTURE, so it serves as the compare reference.
  always_ff @(posedge clk) begin
    if (reset) err <= 1'b0;
    else       err <= (state == S_CAPTURE) && (reg_outa != reg_data);
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed testbench for reg_access_arbiter with a behavioural model of the shared 8-bit register.
// Expected err follows REG_ACCESS_ARBITER_READBACK_CHECK_EN.
module tb_reg_access_arbiter;

  localparam int WIDTH = 8;
  localparam int N_REQ = 4;

`ifdef REG_ACCESS_ARBITER_READBACK_CHECK_EN
  localparam logic EXP_ERR_BAD = 1'b1;
`else
  localparam logic EXP_ERR_BAD = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   reset;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       gnt, done;
  logic [WIDTH-1:0]       rd_data;
  logic                   err, busy, reg_enable, reg_reset_n;
  logic [WIDTH-1:0]       reg_data, reg_outa, reg_q;
  logic                   force_zero;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_access_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .gnt(gnt), .done(done), .rd_data(rd_data), .err(err), .busy(busy),
    .reg_enable(reg_enable), .reg_data(reg_data), .reg_reset_n(reg_reset_n),
    .reg_outa(reg_outa)
  );

  // Model of the external register being shared.
  always @(posedge clk) begin
    if (!reg_reset_n)    reg_q <= '0;
    else if (reg_enable) reg_q <= reg_data;
  end
  assign reg_outa = force_zero ? '0 : reg_q;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    req        = '0;
    req_data   = '0;
    force_zero = 1'b0;

    // 1. Reset
    tick();
    tick();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_rd_data", 32'(rd_data), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_reg_enable", 32'(reg_enable), 32'h0);
    check("rst_reg_data", 32'(reg_data), 32'h0);
    check("rst_reg_reset_n", 32'(reg_reset_n), 32'h0);
    reset = 1'b0;
    tick();
    check("rel_reg_reset_n", 32'(reg_reset_n), 32'h1);
    check("rel_busy", 32'(busy), 32'h0);

    // 2. Single request from requester 2
    req = 4'b0100;
    req_data[2*WIDTH +: WIDTH] = 8'hA5;
    tick();
    check("single_gnt", 32'(gnt), 32'h4);
    check("single_reg_enable", 32'(reg_enable), 32'h1);
    check("single_reg_data", 32'(reg_data), 32'hA5);
    check("single_busy_w", 32'(busy), 32'h1);
    req = '0;
    tick();
    check("single_gnt_off", 32'(gnt), 32'h0);
    check("single_en_off", 32'(reg_enable), 32'h0);
    check("single_reg_data_hold", 32'(reg_data), 32'hA5);
    check("single_busy_c", 32'(busy), 32'h1);
    check("single_done_early", 32'(done), 32'h0);
    tick();
    check("single_done", 32'(done), 32'h4);
    check("single_rd_data", 32'(rd_data), 32'hA5);
    check("single_busy_d", 32'(busy), 32'h1);
    check("single_err", 32'(err), 32'h0);
    tick();
    check("single_idle_busy", 32'(busy), 32'h0);
    check("single_idle_done", 32'(done), 32'h0);

    // 3. Full contention after reset: order 0,1,2,3,0
    do_reset();
    for (int i = 0; i < N_REQ; i++) req_data[i*WIDTH +: WIDTH] = 8'(8'h10 + i);
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      int idx;
      idx = t % N_REQ;
      tick();
      check($sformatf("rr_gnt_%0d", t), 32'(gnt), 32'(1) << idx);
      tick();
      tick();
      check($sformatf("rr_done_%0d", t), 32'(done), 32'(1) << idx);
      check($sformatf("rr_rd_data_%0d", t), 32'(rd_data), 32'(8'h10 + idx));
      tick();
      check($sformatf("rr_idle_busy_%0d", t), 32'(busy), 32'h0);
    end
    req = '0;

    // 4. Reset while in WRITE for requester 1
    req = 4'b0010;
    tick();
    check("abort_gnt1", 32'(gnt), 32'h2);
    reset = 1'b1;
    tick();
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_reg_reset_n", 32'(reg_reset_n), 32'h0);
    reset = 1'b0;
    req   = 4'b0011;
    tick();
    check("abort_next_gnt", 32'(gnt), 32'h1);
    check("abort_no_done", 32'(done), 32'h0);
    req = '0;
    tick();
    check("abort_no_done_c", 32'(done), 32'h0);
    tick();
    check("abort_done0", 32'(done), 32'h1);
    check("abort_rd_data", 32'(rd_data), 32'h10);
    tick();

    // 5. Readback check: forced bad readback, then matching readback
    req_data[0 +: WIDTH] = 8'h3C;
    force_zero = 1'b1;
    req = 4'b0001;
    tick();
    req = '0;
    check("rb_bad_reg_data", 32'(reg_data), 32'h3C);
    tick();
    tick();
    check("rb_bad_done", 32'(done), 32'h1);
    check("rb_bad_rd_data", 32'(rd_data), 32'h00);
    check("rb_bad_err", 32'(err), 32'(EXP_ERR_BAD));
    tick();
    check("rb_err_pulse", 32'(err), 32'h0);
    force_zero = 1'b0;
    req = 4'b0001;
    tick();
    req = '0;
    tick();
    tick();
    check("rb_good_done", 32'(done), 32'h1);
    check("rb_good_rd_data", 32'(rd_data), 32'h3C);
    check("rb_good_err", 32'(err), 32'h0);
    tick();

    // 6. Request pulsed only during CAPTURE is ignored
    req_data[3*WIDTH +: WIDTH] = 8'h77;
    req = 4'b0001;
    tick();
    check("wd_gnt0", 32'(gnt), 32'h1);
    req = '0;
    tick();
    req = 4'b1000;
    tick();
    req = '0;
    check("wd_done0", 32'(done), 32'h1);
    check("wd_gnt_none_d", 32'(gnt), 32'h0);
    tick();
    check("wd_idle_busy", 32'(busy), 32'h0);
    check("wd_gnt_none_i", 32'(gnt), 32'h0);
    tick();
    check("wd_stay_idle", 32'(busy), 32'h0);
    check("wd_gnt_none_2", 32'(gnt), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_access_arbiter.md
Name: reg_access_arbiter

Overview:
- Round-robin arbiter that shares the single 8-bit register datapath (data/enable in, outa out, reset_n) between N_REQ requesters.
- Sequences each access as a fixed write-then-readback transaction.
- Drives the register's control pins and returns the captured outa value to the winning requester.
- Sits between requester agents/blocks and the register DUT, on the same clock.

Parameters:
- WIDTH, 8, register data width.
- N_REQ, 4, number of requesters; legal range 2..16.
- IDX_W, $clog2(N_REQ), width of the winner index and round-robin pointer (derived, not overridden).

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester request level; held until gnt.
- req_data  in  N_REQ*WIDTH  write data; requester i at [i*WIDTH +: WIDTH].
- gnt  out  N_REQ  one-hot, 1-cycle pulse when requester's transaction is issued.
- done  out  N_REQ  one-hot, 1-cycle pulse at transaction completion.
- rd_data  out  WIDTH  outa value captured for the completing transaction; valid while done is high.
- err  out  1  readback-mismatch pulse, coincident with done (see Optional Feature).
- busy  out  1  high whenever state != IDLE.
- reg_enable  out  1  register write enable.
- reg_data  out  WIDTH  register write data.
- reg_reset_n  out  1  active-low reset to register; registered ~reset.
- reg_outa  in  WIDTH  register output.

Behaviour:
- All outputs are registered.
- Reset values (applied on any clk edge with reset=1):
  - state=IDLE, rr_ptr=N_REQ-1.
  - gnt, done, rd_data, err, busy, reg_enable, reg_data = 0; reg_reset_n = 0.
  - reg_reset_n returns to 1 on the first edge with reset=0.
- FSM states: IDLE -> WRITE -> CAPTURE -> DONE -> IDLE.
- IDLE:
  - If req != 0, pick the winner by round-robin search starting at rr_ptr+1 modulo N_REQ.
  - Latch win_idx and req_data[win_idx], set rr_ptr=win_idx, go to WRITE.
  - If req == 0, stay in IDLE.
- WRITE (1 cycle): gnt[win_idx]=1, reg_enable=1, reg_data=latched data. The register loads at the edge ending this cycle.
- CAPTURE (1 cycle): reg_enable=0, reg_data holds. reg_outa is sampled into rd_data at the edge ending this cycle.
- DONE (1 cycle): done[win_idx]=1, rd_data valid, err evaluated. Unconditionally returns to IDLE.
- Latency:
  - Request seen in IDLE at cycle T gives gnt at T+1 and done at T+3.
  - Peak throughput is one transaction per 4 cycles.
- Arbitration happens only in IDLE. Requests that rise and fall while busy are ignored; there is no queuing.
- A requester still holding req after its done is re-arbitrated normally. The rr_ptr rotation prevents starvation: with all N_REQ requesting, each is served once per N_REQ transactions.
- req_data is sampled only in the IDLE->WRITE cycle; later changes have no effect.
- Reset mid-transaction:
  - Returns to IDLE immediately; no done or err is issued for the aborted transaction.
  - rr_ptr resets, so requester 0 wins first afterwards.
- reg_reset_n is never deasserted by the arbiter outside reset.

Optional Feature:
- Macro: REG_ACCESS_ARBITER_READBACK_CHECK_EN.
- Defined:
  - In DONE, err=1 iff rd_data != the latched write data; otherwise err=0.
  - err is a pulse, not sticky.
- Undefined:
  - err tied to 0.
  - No comparator or latched-data compare logic is synthesized; timing is identical.

Test Plan:
1. Reset: reset=1 for 2 cycles -> all outputs 0 and reg_reset_n=0; first edge after release -> reg_reset_n=1, busy=0.
2. Single request: req[2]=1, data2=8'hA5 at cycle T -> gnt=4'b0100 and reg_enable=1, reg_data=8'hA5 at T+1; done=4'b0100 and rd_data=8'hA5 at T+3; busy high T+1..T+3.
3. Contention: req=4'b1111 held, data i = 8'h10+i -> gnt order 0,1,2,3,0 at 4-cycle spacing; each done shows rd_data 8'h10..8'h13.
4. Reset in WRITE: assert reset while gnt[1] is high -> no done[1]; after release with req=4'b0011, the next gnt goes to requester 0.
5. Readback check with macro defined: bench forces reg_outa=8'h00 during a write of 8'h3C -> done with err=1, rd_data=8'h00. Matching readback -> err=0. Macro undefined, same stimulus -> err=0.
6. Withdrawn request: req[3] pulsed high only during CAPTURE of requester 0's transaction -> gnt[3] never asserts and the arbiter returns to IDLE with busy=0.
